// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the iterative datapath units.
package arith_pkg;

    // Default operand/result width for the divider (and, later, the multiplier).
    localparam int DEFAULT_LEN = 32;

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

    // Width of the step counter for a LEN-bit operation.
    function automatic int cnt_width(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/divider_if.sv
// Start/finish handshake bundle shared by the divider and its driver.
interface divider_if import arith_pkg::*; #(
    parameter int LEN = DEFAULT_LEN
);

    logic [LEN-1:0] dividend;
    logic [LEN-1:0] divisor;
    logic           start;
    logic [LEN-1:0] quotient;
    logic [LEN-1:0] remainder;
    logic           finish;
    logic           busy;

    // Requester side: presents operands and start, observes results.
    modport master (
        output dividend,
        output divisor,
        output start,
        input  quotient,
        input  remainder,
        input  finish,
        input  busy
    );

    // Divider side: samples operands on acceptance, returns results.
    modport slave (
        input  dividend,
        input  divisor,
        input  start,
        output quotient,
        output remainder,
        output finish,
        output busy
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, then
// subtract the divisor if it fits.
module div_step import arith_pkg::*; #(
    parameter int LEN = DEFAULT_LEN
) (
    input  logic [LEN:0]   rem_r,
    input  logic           q_msb,
    input  logic [LEN-1:0] dvsr,
    output logic [LEN:0]   rem_next,
    output logic           q_bit
);

    logic [LEN:0] trial;
    logic [LEN:0] dvsr_ext;
    logic         unused_rem_msb;

    // The partial remainder always stays below the divisor, so its top bit
    // carries no information into the shifted trial value.
    assign unused_rem_msb = rem_r[LEN];
    assign trial          = {rem_r[LEN-1:0], q_msb};
    assign dvsr_ext       = {1'b0, dvsr};

    // Compare and conditionally subtract at LEN+1 bits.
    always_comb begin
        q_bit    = 1'b0;
        rem_next = trial;
        if (trial >= dvsr_ext) begin
            q_bit    = 1'b1;
            rem_next = trial - dvsr_ext;
        end
    end

endmodule

// File: rtl/divider.sv
// Unsigned iterative restoring divider, one quotient bit per cycle,
// with a start/finish handshake.
module divider import arith_pkg::*; #(
    parameter int LEN = DEFAULT_LEN
) (
    input  logic     clk,
    input  logic     rstn,
    divider_if.slave bus
);

    localparam int                 CNT_W    = cnt_width(LEN);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(LEN - 1);

    div_state_t       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [LEN-1:0]   dvsr_q,   dvsr_d;
    logic [LEN-1:0]   q_q,      q_d;
    logic [LEN:0]     rem_q,    rem_d;
    logic [LEN-1:0]   quot_q,   quot_d;
    logic [LEN-1:0]   remd_q,   remd_d;
    logic             finish_q, finish_d;
    logic             busy_q,   busy_d;

    logic [LEN:0]     step_rem;
    logic             step_bit;

    div_step #(
        .LEN (LEN)
    ) u_step (
        .rem_r    (rem_q),
        .q_msb    (q_q[LEN-1]),
        .dvsr     (dvsr_q),
        .rem_next (step_rem),
        .q_bit    (step_bit)
    );

    // State, datapath and result registers with asynchronous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dvsr_q   <= '0;
            q_q      <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            remd_q   <= '0;
            finish_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvsr_q   <= dvsr_d;
            q_q      <= q_d;
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            remd_q   <= remd_d;
            finish_q <= finish_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state logic: accept in IDLE, LEN restoring steps in CALC,
    // publish results on the edge that leaves DONE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvsr_d   = dvsr_q;
        q_d      = q_q;
        rem_d    = rem_q;
        quot_d   = quot_q;
        remd_d   = remd_q;
        finish_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dvsr_d  = bus.divisor;
                    q_d     = bus.dividend;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                rem_d = step_rem;
                q_d   = {q_q[LEN-2:0], step_bit};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Capturing here rather than on the last CALC edge gives the
                // registered finish/result one cycle after the final step.
                quot_d   = q_q;
                remd_d   = rem_q[LEN-1:0];
                finish_d = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Busy covers CALC, DONE and the cycle in which finish is shown.
        busy_d = (state_d != IDLE) || finish_d;
    end

    assign bus.quotient  = quot_q;
    assign bus.remainder = remd_q;
    assign bus.finish    = finish_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for the iterative divider.
module tb_divider;
    import arith_pkg::*;

    localparam int LEN = DEFAULT_LEN;

    logic        clk = 1'b0;
    logic        rstn;
    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    divider_if #(.LEN(LEN)) bus ();

    divider #(.LEN(LEN)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference: plain unsigned division; divide by zero gives all ones
    // and returns the dividend as remainder.
    function automatic logic [2*LEN-1:0] ref_div(input logic [LEN-1:0] a,
                                                 input logic [LEN-1:0] b);
        if (b == '0) return {{LEN{1'b1}}, a};
        return {a / b, a % b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [2*LEN+1:0] obs;
        rstn = 1'b0;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (3) tick();
        obs = {bus.quotient, bus.remainder, bus.finish, bus.busy};
        n_total++;
        if (obs !== '0) $display("FAIL reset_outputs: got %h want 0", obs);
        else n_pass++;
        rstn = 1'b1;
        repeat (2) tick();
        obs = {bus.quotient, bus.remainder, bus.finish, bus.busy};
        n_total++;
        if (obs !== '0) $display("FAIL idle_after_release: got %h want 0", obs);
        else n_pass++;
    endtask

    // Single operation with exact edge timing; DUT must be idle on entry.
    task automatic run_one(input logic [LEN-1:0] a, input logic [LEN-1:0] b);
        logic [2*LEN-1:0] exp;
        int unsigned      early;
        exp   = ref_div(a, b);
        early = 0;
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        tick();                                   // E0
        bus.start    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
        n_total++;
        if (bus.busy !== 1'b1) $display("FAIL busy_rise %h/%h: got %b want 1", a, b, bus.busy);
        else n_pass++;
        for (int k = 1; k <= LEN; k++) begin      // E1..ELEN
            tick();
            if (bus.finish !== 1'b0) early++;
        end
        tick();                                   // ELEN+1
        n_total++;
        if ({bus.finish, bus.busy, bus.quotient, bus.remainder} !== {1'b1, 1'b1, exp} || early != 0)
            $display("FAIL result %h/%h: got fin=%b busy=%b q=%h r=%h early=%0d want fin=1 busy=1 q=%h r=%h early=0",
                     a, b, bus.finish, bus.busy, bus.quotient, bus.remainder, early,
                     exp[2*LEN-1:LEN], exp[LEN-1:0]);
        else n_pass++;
        tick();                                   // ELEN+2
        n_total++;
        if ({bus.finish, bus.busy, bus.quotient, bus.remainder} !== {1'b0, 1'b0, exp})
            $display("FAIL hold %h/%h: got fin=%b busy=%b q=%h r=%h want fin=0 busy=0 q=%h r=%h",
                     a, b, bus.finish, bus.busy, bus.quotient, bus.remainder,
                     exp[2*LEN-1:LEN], exp[LEN-1:0]);
        else n_pass++;
    endtask

    task automatic test_divide();
        run_one(32'd100, 32'd7);
        run_one(32'hFFFF_FFFF, 32'd1);
        run_one(32'd5, 32'd0);
        run_one(32'd3, 32'd10);
        run_one(32'h8000_0000, 32'h8000_0000);
    endtask

    task automatic test_start_ignored();
        logic [2*LEN-1:0] exp;
        logic [2*LEN-1:0] got;
        int unsigned      nfin;
        int unsigned      fin_at;
        exp    = ref_div(32'd100, 32'd7);
        got    = '0;
        nfin   = 0;
        fin_at = 0;
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        bus.start    = 1'b1;
        tick();                                   // E0
        bus.start = 1'b0;
        for (int k = 1; k <= LEN + 8; k++) begin
            tick();
            if (k == 9) begin
                bus.start    = 1'b1;              // sampled at E10, during CALC
                bus.dividend = 32'd55;
                bus.divisor  = 32'd3;
            end
            if (k == 10) bus.start = 1'b0;
            if (bus.finish === 1'b1) begin
                nfin++;
                fin_at = k;
                got = {bus.quotient, bus.remainder};
            end
        end
        n_total++;
        if (nfin != 1 || fin_at != LEN + 1 || got !== exp)
            $display("FAIL start_ignored: got finishes=%0d at=E%0d q/r=%h want finishes=1 at=E%0d q/r=%h",
                     nfin, fin_at, got, LEN + 1, exp);
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        logic [2*LEN+1:0] obs;
        int unsigned      nfin;
        nfin = 0;
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        bus.start    = 1'b1;
        tick();                                   // E0
        bus.start = 1'b0;
        repeat (14) tick();                       // through E14
        @(posedge clk);                           // E15
        #2;
        rstn = 1'b0;
        #1;
        obs = {bus.quotient, bus.remainder, bus.finish, bus.busy};
        n_total++;
        if (obs !== '0) $display("FAIL abort_clear: got %h want 0", obs);
        else n_pass++;
        repeat (2) tick();
        rstn = 1'b1;
        for (int k = 0; k < LEN + 8; k++) begin
            tick();
            if (bus.finish !== 1'b0 || bus.busy !== 1'b0) nfin++;
        end
        n_total++;
        if (nfin != 0) $display("FAIL abort_no_finish: got %0d active cycles want 0", nfin);
        else n_pass++;
        run_one(32'd9, 32'd4);
    endtask

    task automatic test_back_to_back();
        logic [LEN-1:0]   a_q[$];
        logic [LEN-1:0]   b_q[$];
        logic [2*LEN-1:0] exp;
        logic [LEN-1:0]   a;
        logic [LEN-1:0]   b;
        int unsigned      bad;
        bad = 0;
        for (int k = 0; k < 64; k++) begin
            a = $urandom;
            if (k % 5 == 0) a = $urandom_range(0, 100);
            if (k % 8 == 0)      b = '0;
            else if (k % 4 == 1) b = $urandom_range(1, 15);
            else if (k % 4 == 2) b = $urandom >> $urandom_range(0, 31);
            else                 b = $urandom;
            a_q.push_back(a);
            b_q.push_back(b);
        end
        bus.dividend = a_q[0];
        bus.divisor  = b_q[0];
        bus.start    = 1'b1;
        for (int k = 0; k < 64; k++) begin
            exp = ref_div(a_q[k], b_q[k]);
            tick();                               // accepting edge
            if (k < 63) begin
                bus.dividend = a_q[k+1];
                bus.divisor  = b_q[k+1];
            end else begin
                bus.start = 1'b0;
            end
            for (int c = 1; c <= LEN; c++) begin
                tick();
                if (bus.finish !== 1'b0 || bus.busy !== 1'b1) bad++;
            end
            tick();                               // finish edge, LEN+2 after previous
            n_total++;
            if ({bus.finish, bus.busy, bus.quotient, bus.remainder} !== {1'b1, 1'b1, exp})
                $display("FAIL b2b[%0d] %h/%h: got fin=%b busy=%b q=%h r=%h want fin=1 busy=1 q=%h r=%h",
                         k, a_q[k], b_q[k], bus.finish, bus.busy, bus.quotient, bus.remainder,
                         exp[2*LEN-1:LEN], exp[LEN-1:0]);
            else n_pass++;
        end
        tick();
        n_total++;
        if (bad != 0 || bus.finish !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL b2b_spacing: got bad_cycles=%0d fin=%b busy=%b want 0 0 0",
                     bad, bus.finish, bus.busy);
        else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_divide();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
